// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use stall, branch flush,
// EX operand forwarding selects, and saturating stall/flush event counters.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction_IFID_in,
    input  logic             RegWEn_ID,
    input  logic [1:0]       WBsel_ID,
    input  logic             PCSel,
    output logic             stall_IF,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic [1:0]       fwdA_sel,
    output logic [1:0]       fwdB_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic       r_exValid, r_exRegwen, r_exLoad, r_exUse1, r_exUse2;
    logic [4:0] r_exRd, r_exRs1, r_exRs2;
    logic       r_memValid, r_memRegwen, r_memLoad;
    logic [4:0] r_memRd;
    logic       r_wbValid, r_wbRegwen, r_wbLoad;
    logic [4:0] r_wbRd;
    logic [CNT_W-1:0] r_stallCount, r_flushCount;

    logic [6:0] w_opcode;
    logic [4:0] w_rd, w_rs1, w_rs2;
    logic       w_useRs1, w_useRs2, w_loadUse, w_flushIDEX;
    logic       w_unusedBits;

    assign w_opcode = instruction_IFID_in[6:0];
    assign w_rd     = instruction_IFID_in[11:7];
    assign w_rs1    = instruction_IFID_in[19:15];
    assign w_rs2    = instruction_IFID_in[24:20];
    assign w_useRs1 = !(w_opcode == OP_LUI || w_opcode == OP_AUIPC || w_opcode == OP_JAL);
    assign w_useRs2 = (w_opcode == OP_RTYPE) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);

    // Load-use: the load in EX cannot supply its data until WB, so the ID consumer must wait a cycle.
    assign w_loadUse = r_exValid && r_exRegwen && r_exLoad && (r_exRd != 5'd0) &&
                       ((w_useRs1 && (w_rs1 == r_exRd)) || (w_useRs2 && (w_rs2 == r_exRd)));
    assign w_flushIDEX = PCSel || w_loadUse;

    // Funct fields and the older stages' load flags carry no hazard information.
    assign w_unusedBits = ^{instruction_IFID_in[31:25], instruction_IFID_in[14:12], r_memLoad, r_wbLoad};

    function automatic logic [1:0] fwdSelect(
        input logic       useRs,
        input logic [4:0] rs,
        input logic       memValid,
        input logic       memRegwen,
        input logic [4:0] memRd,
        input logic       wbValid,
        input logic       wbRegwen,
        input logic [4:0] wbRd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (useRs && memValid && memRegwen && (memRd != 5'd0) && (memRd == rs)) begin
            sel = 2'b01;
        end else if (useRs && wbValid && wbRegwen && (wbRd != 5'd0) && (wbRd == rs)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    assign flush_IFID = !reset && PCSel;
    assign flush_IDEX = !reset && w_flushIDEX;
    assign stall_IF   = !reset && w_loadUse && !PCSel;
    assign fwdA_sel   = reset ? 2'b00 : fwdSelect(r_exUse1, r_exRs1, r_memValid, r_memRegwen, r_memRd,
                                                  r_wbValid, r_wbRegwen, r_wbRd);
    assign fwdB_sel   = reset ? 2'b00 : fwdSelect(r_exUse2, r_exRs2, r_memValid, r_memRegwen, r_memRd,
                                                  r_wbValid, r_wbRegwen, r_wbRd);

    always_ff @(posedge clk) begin
        if (reset) begin
            {r_exValid, r_exRegwen, r_exLoad, r_exUse1, r_exUse2} <= '0;
            {r_exRd, r_exRs1, r_exRs2} <= '0;
            {r_memValid, r_memRegwen, r_memLoad, r_memRd} <= '0;
            {r_wbValid, r_wbRegwen, r_wbLoad, r_wbRd} <= '0;
        end else begin
            {r_wbValid, r_wbRegwen, r_wbLoad, r_wbRd}     <= {r_memValid, r_memRegwen, r_memLoad, r_memRd};
            {r_memValid, r_memRegwen, r_memLoad, r_memRd} <= {r_exValid, r_exRegwen, r_exLoad, r_exRd};
            // A bubble clears every field so stale sources never drive forwarding.
            if (w_flushIDEX) begin
                {r_exValid, r_exRegwen, r_exLoad, r_exUse1, r_exUse2} <= '0;
                {r_exRd, r_exRs1, r_exRs2} <= '0;
            end else begin
                r_exValid  <= 1'b1;
                r_exRegwen <= RegWEn_ID;
                r_exLoad   <= (WBsel_ID == 2'b00);
                r_exUse1   <= w_useRs1;
                r_exUse2   <= w_useRs2;
                r_exRd     <= w_rd;
                r_exRs1    <= w_rs1;
                r_exRs2    <= w_rs2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (stall_IF && (r_stallCount != CNT_MAX)) begin
                r_stallCount <= r_stallCount + CNT_ONE;
            end
            if (flush_IFID && (r_flushCount != CNT_MAX)) begin
                r_flushCount <= r_flushCount + CNT_ONE;
            end
        end
    end

    assign stall_count = r_stallCount;
    assign flush_count = r_flushCount;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RV32I core. It keeps a shadow copy of the destination and source registers of instructions in EX, MEM and WB. From this state it generates three kinds of output:
- load-use stall and bubble-insertion controls for the IF/ID and ID/EX pipeline registers;
- a flush on a taken branch or jump;
- ALU operand forwarding selects for the instruction in EX.

It sits beside the decode stage, consumes decode-stage control signals and the EX-stage `PCSel`, and drives the ID/EX register's bubble mux. It also keeps two saturating event counters for performance visibility.

## Interface
Parameters:
- `CNT_W`, 16, width of the stall and flush event counters

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `instruction_IFID_in`  in  32  instruction currently in ID
- `RegWEn_ID`  in  1  ID instruction writes `rd`
- `WBsel_ID`  in  2  ID writeback select; `2'b00` = memory (load)
- `PCSel`  in  1  taken branch/jump resolved in EX this cycle
- `stall_IF`  out  1  hold PC and IF/ID this cycle
- `flush_IFID`  out  1  replace IF/ID contents with NOP (`32'h00000013`) at next edge
- `flush_IDEX`  out  1  load bubble (all controls 0, `RegWEn`=0, `MemRW`=0) into ID/EX at next edge
- `fwdA_sel`  out  2  EX operand A source: `00` regfile, `01` EX/MEM writeback value, `10` MEM/WB writeback value
- `fwdB_sel`  out  2  EX operand B source, same encoding
- `stall_count`  out  `CNT_W`  cycles with `stall_IF`=1, saturating
- `flush_count`  out  `CNT_W`  cycles with `flush_IFID`=1, saturating

## Operation
- Shadow entries `ex`, `mem`, `wb`. Each entry holds:
  - `valid`, `rd[4:0]`, `regwen`, `is_load`;
  - `ex` additionally holds `rs1`, `rs2`, `use_rs1`, `use_rs2`.
- Decode of `instruction_IFID_in`:
  - `rd`=[11:7], `rs1`=[19:15], `rs2`=[24:20];
  - `use_rs1`=0 only for opcodes `0110111` (LUI), `0010111` (AUIPC), `1101111` (JAL);
  - `use_rs2`=1 only for opcodes `0110011`, `0100011`, `1100011`.
- Load-use hazard (`lu`), true when all hold:
  - `ex.valid`, `ex.regwen`, `ex.is_load`, `ex.rd`≠0;
  - the ID instruction uses `rs1` or `rs2` and that field equals `ex.rd`.
- Output logic, combinational from shadow state and inputs:
  - `flush_IFID` = `PCSel`
  - `flush_IDEX` = `PCSel` | `lu`
  - `stall_IF` = `lu` & ~`PCSel`; a taken branch overrides the stall because the ID instruction is wrong-path.
- Forwarding for A; B is identical using `rs2`/`use_rs2`:
  - `01` if `ex.use_rs1`, `mem.valid`, `mem.regwen`, `mem.rd`≠0 and `mem.rd`==`ex.rs1`;
  - else `10` if the same conditions hold for `wb`;
  - else `00`. MEM takes priority over WB (youngest producer wins).
- `x0` is never forwarded and never causes a stall.
- Shadow advance on every non-reset edge:
  - `wb`←`mem` and `mem`←`ex`;
  - `ex`←invalid if `flush_IDEX`, else the decoded ID instruction with `valid`=1, `regwen`=`RegWEn_ID` and `is_load`=(`WBsel_ID`==`2'b00`).
- A stall does not freeze `mem` or `wb`; only IF/ID holds.
- Counters:
  - `stall_count` +1 on each edge where `stall_IF`=1;
  - `flush_count` +1 on each edge where `flush_IFID`=1;
  - both hold at all-ones (no wrap).
- The register file is write-through, so the unit does not forward WB-to-ID.

## Timing
- Reset, on the edge with `reset`=1:
  - all shadow `valid`=0 and counters=0.
- While `reset`=1:
  - `stall_IF`, `flush_IFID`, `flush_IDEX` are forced 0 and `fwdA_sel`/`fwdB_sel` are forced `00`, regardless of `PCSel`.
- After reset, all outputs are 0/`00` until valid instructions enter.
- Load-use costs exactly one stall cycle:
  - next cycle the load is in MEM, the `ex` slot holds the bubble, and no hazard remains;
  - one cycle later the consumer is in EX with the load in WB, so fwd=`10`.
- A taken branch costs one flush cycle, affecting two instructions (IF/ID and ID/EX).
- Reset asserted mid-stall or mid-flush:
  - shadow is cleared at that edge;
  - no residual stall/flush after deassertion.
- Back-to-back loads feeding each other stall once per dependent pair.

## Test plan
- Reset with `PCSel`=1 held high -> all control outputs 0 and `fwd` `00` throughout reset; both counters 0 after release.
- `add x1,x2,x3` (`003100B3`) then `sub x4,x1,x5` (`40508233`) -> `fwdA_sel`=`01`, `fwdB_sel`=`00` in the cycle `sub` is in EX; with one independent instruction between them -> `fwdA_sel`=`10`.
- `lw x6,0(x7)` (`0003A303`) then `add x8,x6,x6` (`00630433`):
  - -> `stall_IF`=1 and `flush_IDEX`=1 for exactly one cycle;
  - -> then `fwdA_sel`=`fwdB_sel`=`10` when `add` is in EX;
  - -> `stall_count`=1.
- `lw x6` followed by `add x0,x6,x0`, then `lw x0` followed by `add x9,x0,x0`:
  - -> stall for the first pair only (rs1=x6 matches a non-zero `rd`);
  - -> no stall and no forwarding for `x0` in the second.
- Load-use hazard in the same cycle as `PCSel`=1 -> `stall_IF`=0, `flush_IFID`=`flush_IDEX`=1; `flush_count` +1, `stall_count` unchanged.
- Force 65 537 stall cycles -> `stall_count` saturates at `16'hFFFF`.
